// File: rtl/pixel_scan_counter_pkg.sv
// Shared camera-path package: sensor geometry, decimation factors and a clog2 helper for
// deriving counter widths.
package cam_pkg;

    localparam int unsigned CAM_H_ACTIVE = 640;
    localparam int unsigned CAM_V_ACTIVE = 480;

    localparam int unsigned DEC_NONE = 1;
    localparam int unsigned DEC_HALF = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pixel_scan_counter_if.sv
// Pixel scan bus: pixel-accept strobes from the capture stage and position/address/terminal
// outputs toward the frame-buffer write port.
interface pixel_scan_counter_if #(
    parameter int unsigned XW  = 10,
    parameter int unsigned YW  = 9,
    parameter int unsigned AW  = 19,
    parameter int unsigned FCW = 8
);
    logic           clr;
    logic           en;
    logic [XW-1:0]  x_cnt;
    logic [YW-1:0]  y_cnt;
    logic [AW-1:0]  wr_addr;
    logic           wr_en;
    logic           line_end;
    logic           frame_end;
    logic [FCW-1:0] frame_cnt;

    modport master (
        output clr, en,
        input  x_cnt, y_cnt, wr_addr, wr_en, line_end, frame_end, frame_cnt
    );

    modport slave (
        input  clr, en,
        output x_cnt, y_cnt, wr_addr, wr_en, line_end, frame_end, frame_cnt
    );
endinterface

// File: rtl/pixel_scan_counter_axis.sv
// scan_axis_counter: one raster axis counting 0..LIMIT-1 and wrapping; clr returns to origin
// and overrides step.
module scan_axis_counter #(
    parameter int unsigned W     = 10,
    parameter int unsigned LIMIT = 640
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         at_limit
);

    logic [W-1:0] count_q, count_d;

    assign at_limit = (count_q == W'(LIMIT - 1));
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (step) begin
            count_d = at_limit ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pixel_scan_counter.sv
// 2-D raster counter producing frame-buffer write addresses with optional 2:1 decimation.
// Define PSC_FRAME_COUNT_EN to build the completed-frame counter; otherwise frame_cnt is 0.
module pixel_scan_counter
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = CAM_H_ACTIVE,
    parameter int unsigned V_ACTIVE = CAM_V_ACTIVE,
    parameter int unsigned DEC      = DEC_NONE,
    parameter int unsigned XW       = clog2(H_ACTIVE),
    parameter int unsigned YW       = clog2(V_ACTIVE),
    parameter int unsigned AW       = clog2((H_ACTIVE / DEC) * (V_ACTIVE / DEC)),
    parameter int unsigned FCW      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    pixel_scan_counter_if.slave bus
);

    // Even-sized region kept under 2:1 decimation; a trailing odd column/row falls outside.
    localparam int unsigned HKeep = (H_ACTIVE / 2) * 2;
    localparam int unsigned VKeep = (V_ACTIVE / 2) * 2;

    logic          accept;
    logic          x_last, y_last;
    logic          frame_wrap;
    logic          kept;
    logic          wr_en;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;

    logic [AW-1:0] addr_q, addr_d;
    logic          line_end_q, line_end_d;
    logic          frame_end_q, frame_end_d;

    assign accept     = bus.en & ~bus.clr;
    assign frame_wrap = accept & x_last & y_last;

    scan_axis_counter #(
        .W     (XW),
        .LIMIT (H_ACTIVE)
    ) u_x_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.clr),
        .step     (accept),
        .count    (x_cnt),
        .at_limit (x_last)
    );

    scan_axis_counter #(
        .W     (YW),
        .LIMIT (V_ACTIVE)
    ) u_y_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.clr),
        .step     (accept & x_last),
        .count    (y_cnt),
        .at_limit (y_last)
    );

    if (DEC == DEC_NONE) begin : g_keep_all
        assign kept = 1'b1;
    end else if (DEC == DEC_HALF) begin : g_keep_half
        assign kept = ~x_cnt[0] & ~y_cnt[0] & (x_cnt < XW'(HKeep)) & (y_cnt < YW'(VKeep));
    end else begin : g_bad_dec
        $error("pixel_scan_counter: DEC must be 1 or 2");
        assign kept = 1'b0;
    end

    assign wr_en = accept & kept;

    always_comb begin
        addr_d = addr_q;
        if (bus.clr || frame_wrap) begin
            addr_d = '0;
        end else if (wr_en) begin
            addr_d = addr_q + AW'(1);
        end
        line_end_d  = accept & x_last;
        frame_end_d = frame_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
        end
    end

`ifdef PSC_FRAME_COUNT_EN
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = frame_wrap ? frame_cnt_q + FCW'(1) : frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`else
    assign bus.frame_cnt = '0;
`endif

    assign bus.x_cnt     = x_cnt;
    assign bus.y_cnt     = y_cnt;
    assign bus.wr_addr   = addr_q;
    assign bus.wr_en     = wr_en;
    assign bus.line_end  = line_end_q;
    assign bus.frame_end = frame_end_q;

endmodule

// File: tb/tb_pixel_scan_counter.sv
// Directed bench for pixel_scan_counter on an 8x4 raster: one DEC=1 instance driven against a
// reference scan model, one DEC=2 instance checked against hand-derived keep positions.
module tb_pixel_scan_counter;

    localparam int unsigned H   = 8;
    localparam int unsigned V   = 4;
    localparam int unsigned XW  = 4;
    localparam int unsigned YW  = 3;
    localparam int unsigned AW  = 6;
    localparam int unsigned FCW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pixel_scan_counter_if #(.XW(XW), .YW(YW), .AW(AW), .FCW(FCW)) bus1 ();
    pixel_scan_counter_if #(.XW(XW), .YW(YW), .AW(AW), .FCW(FCW)) bus2 ();

    pixel_scan_counter #(
        .H_ACTIVE (H), .V_ACTIVE (V), .DEC (1), .XW (XW), .YW (YW), .AW (AW), .FCW (FCW)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    pixel_scan_counter #(
        .H_ACTIVE (H), .V_ACTIVE (V), .DEC (2), .XW (XW), .YW (YW), .AW (AW), .FCW (FCW)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference scan position for the DEC=1 instance.
    int mx = 0, my = 0, ma = 0, fc = 0;
    bit mle = 1'b0, mfe = 1'b0;

`ifdef PSC_FRAME_COUNT_EN
    int fc_tab[5] = '{1, 2, 3, 0, 1};
`else
    int fc_tab[5] = '{0, 0, 0, 0, 0};
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle on dut1: drive, check against the model, clock, advance the model.
    task automatic cyc(input bit en_v, input bit clr_v);
        bus1.en  = en_v;
        bus1.clr = clr_v;
        #1;
        check("x_cnt", bus1.x_cnt, mx);
        check("y_cnt", bus1.y_cnt, my);
        check("wr_addr", bus1.wr_addr, ma);
        check("wr_en", bus1.wr_en, en_v & ~clr_v);
        check("line_end", bus1.line_end, mle);
        check("frame_end", bus1.frame_end, mfe);
        check("frame_cnt", bus1.frame_cnt, fc);
        @(posedge clk);
        #1;
        if (clr_v) begin
            mx = 0; my = 0; ma = 0; mle = 1'b0; mfe = 1'b0;
        end else if (en_v) begin
            mle = (mx == H - 1);
            mfe = mle && (my == V - 1);
            ma  = mfe ? 0 : ma + 1;
            if (mle) begin
                mx = 0;
                my = (my == V - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
`ifdef PSC_FRAME_COUNT_EN
            if (mfe) fc = (fc + 1) % 4;
`endif
        end else begin
            mle = 1'b0;
            mfe = 1'b0;
        end
    endtask

    initial begin
        int k2;
        int n_wr2;
        bus1.en = 1'b0; bus1.clr = 1'b0;
        bus2.en = 1'b0; bus2.clr = 1'b0;

        // Reset state
        #2;
        check("rst_x", bus1.x_cnt, 0);
        check("rst_y", bus1.y_cnt, 0);
        check("rst_addr", bus1.wr_addr, 0);
        check("rst_line_end", bus1.line_end, 0);
        check("rst_frame_end", bus1.frame_end, 0);
        check("rst_frame_cnt", bus1.frame_cnt, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous frame: addresses 0..31, then wrap with both pulses
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0);
        check("t1_wrap_addr", bus1.wr_addr, 0);
        check("t1_line_end", bus1.line_end, 1);
        check("t1_frame_end", bus1.frame_end, 1);
        check("t1_frame_cnt", bus1.frame_cnt, fc_tab[0]);
        cyc(1'b0, 1'b0);
        check("t1_pulse_drop", bus1.frame_end, 0);

        // Alternating en: same sequence stretched, holding in idle cycles
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
        check("t3_frame_cnt", bus1.frame_cnt, fc_tab[1]);

        // Three more frames for the frame counter
        for (int f = 2; f < 5; f++) begin
            for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0);
            check("t6_frame_end", bus1.frame_end, 1);
            check("t6_frame_cnt", bus1.frame_cnt, fc_tab[f]);
        end
        cyc(1'b0, 1'b0);

        // DEC=2: keep even x on even y, addresses 0..7
        k2    = 0;
        n_wr2 = 0;
        for (int i = 0; i < 32; i++) begin
            bus2.en = 1'b1;
            #1;
            if (((i % 8) % 2 == 0) && ((i / 8) % 2 == 0)) begin
                check("t2_wr_en_kept", bus2.wr_en, 1);
                check("t2_addr", bus2.wr_addr, k2);
                k2++;
            end else begin
                check("t2_wr_en_drop", bus2.wr_en, 0);
            end
            if (bus2.wr_en === 1'b1) n_wr2++;
            @(posedge clk);
            #1;
        end
        bus2.en = 1'b0;
        #1;
        check("t2_wr_count", n_wr2, 8);
        check("t2_end_addr", bus2.wr_addr, 0);
        check("t2_frame_end", bus2.frame_end, 1);

        // clr with en at (5,2)
        for (int i = 0; i < 21; i++) cyc(1'b1, 1'b0);
        check("t4_x_before", bus1.x_cnt, 5);
        check("t4_y_before", bus1.y_cnt, 2);
        check("t4_addr_before", bus1.wr_addr, 21);
        cyc(1'b1, 1'b1);
        check("t4_x", bus1.x_cnt, 0);
        check("t4_y", bus1.y_cnt, 0);
        check("t4_addr", bus1.wr_addr, 0);
        check("t4_line_end", bus1.line_end, 0);
        check("t4_frame_end", bus1.frame_end, 0);
        cyc(1'b0, 1'b0);

        // Asynchronous reset mid-frame at (3,1)
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0);
        check("t5_x_before", bus1.x_cnt, 3);
        check("t5_y_before", bus1.y_cnt, 1);
        check("t5_addr_before", bus1.wr_addr, 11);
        bus1.en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("t5_x", bus1.x_cnt, 0);
        check("t5_y", bus1.y_cnt, 0);
        check("t5_addr", bus1.wr_addr, 0);
        check("t5_line_end", bus1.line_end, 0);
        check("t5_frame_end", bus1.frame_end, 0);
        check("t5_frame_cnt", bus1.frame_cnt, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mx = 0; my = 0; ma = 0; fc = 0; mle = 1'b0; mfe = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        check("t5_restart_addr", bus1.wr_addr, 3);
        check("t5_restart_x", bus1.x_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
